// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: shift-add significand multiply over N cycles,
// followed by normalise, round (RNE/RTZ) and range check, behind a start/done handshake.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BPC   = 1,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         rm_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] product_o,
    output logic         nan_o,
    output logic         infinite_o,
    output logic         overflow_o,
    output logic         underflow_o,
    output logic         inexact_o
);
    localparam int M    = MAN_W + 1;
    localparam int N    = (M + BPC - 1) / BPC;
    localparam int PW   = 2 * M;
    localparam int MW   = N * BPC;
    localparam int XW   = EXP_W + 2;
    localparam int CW   = $clog2(N + 1);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

    state_t         state_q, state_d;
    special_t       special_q, special_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, product_q, product_d;
    logic           rm_q, rm_d, sign_q, sign_d;
    logic [XW-1:0]  exp_q, exp_d;
    logic [PW-1:0]  acc_q, acc_d, mcand_q, mcand_d;
    logic [MW-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   sig_q, sig_d;
    logic           g_q, g_d, s_q, s_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [PW-1:0]    pp;
    logic             inc, carry, ovf_w, unf_w;
    logic [M:0]       rnd;
    logic [MAN_W-1:0] frac_r;
    logic [XW-1:0]    exp_r;
    logic [W-1:0]     res_w;
    logic [4:0]       flags_w;

    always_comb begin
        ea     = a_q[W-2:MAN_W];
        eb     = b_q[W-2:MAN_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        pp     = mcand_q * PW'(mplier_q[BPC-1:0]);
    end

    // Rounding and range check; the ROUND state latches this into the outputs.
    always_comb begin
        inc    = ~rm_q & g_q & (s_q | sig_q[0]);
        rnd    = {1'b0, sig_q} + (M+1)'(inc);
        carry  = rnd[M];
        frac_r = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        exp_r  = exp_q + XW'(carry);
        ovf_w  = $signed(exp_r) >= $signed(XW'(EMAX));
        unf_w  = $signed(exp_r) < $signed(XW'(1));
        res_w  = {sign_q, exp_r[EXP_W-1:0], frac_r};
        flags_w = {4'b0000, g_q | s_q};
        case (special_q)
            SP_NAN: begin
                res_w   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flags_w = 5'b10000;
            end
            SP_INF: begin
                res_w   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_w = 5'b01000;
            end
            SP_ZERO: begin
                res_w   = {sign_q, {(W-1){1'b0}}};
                flags_w = 5'b00000;
            end
            default: begin
                if (ovf_w) begin
                    if (rm_q) begin
                        res_w   = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                        flags_w = 5'b00101;
                    end else begin
                        res_w   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_w = 5'b01101;
                    end
                end else if (unf_w) begin
                    res_w   = {sign_q, {(W-1){1'b0}}};
                    flags_w = 5'b00011;
                end
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        special_d = special_q;
        a_d       = a_q;
        b_d       = b_q;
        rm_d      = rm_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        sig_d     = sig_q;
        g_d       = g_q;
        s_d       = s_q;
        busy_d    = busy_q;
        done_d    = done_q;
        product_d = product_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inx_d     = inx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_UNPACK;
                    a_d     = a_i;
                    b_d     = b_i;
                    rm_d    = rm_i;
                    busy_d  = 1'b1;
                end
            end
            S_UNPACK: begin
                state_d  = S_MULT;
                sign_d   = a_q[W-1] ^ b_q[W-1];
                exp_d    = XW'(ea) + XW'(eb) - XW'(BIAS);
                acc_d    = '0;
                mcand_d  = PW'({1'b1, fa});
                mplier_d = MW'({1'b1, fb});
                cnt_d    = '0;
                if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
                    special_d = SP_NAN;
                else if (a_inf | b_inf)
                    special_d = SP_INF;
                else if (a_zero | b_zero)
                    special_d = SP_ZERO;
                else
                    special_d = SP_NONE;
            end
            S_MULT: begin
                acc_d    = acc_q + pp;
                mcand_d  = mcand_q << BPC;
                mplier_d = mplier_q >> BPC;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1))
                    state_d = S_NORM;
            end
            S_NORM: begin
                state_d = S_ROUND;
                exp_d   = exp_q + XW'(acc_q[PW-1]);
                if (acc_q[PW-1]) begin
                    sig_d = acc_q[PW-1:M];
                    g_d   = acc_q[M-1];
                    s_d   = |acc_q[M-2:0];
                end else begin
                    sig_d = acc_q[PW-2:M-1];
                    g_d   = acc_q[M-2];
                    s_d   = |acc_q[M-3:0];
                end
            end
            S_ROUND: begin
                state_d   = S_DONE;
                done_d    = 1'b1;
                product_d = res_w;
                {nan_d, inf_d, ovf_d, unf_d, inx_d} = flags_w;
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            special_q <= SP_NONE;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            sig_q     <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            special_q <= special_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rm_q      <= rm_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            sig_q     <= sig_d;
            g_q       <= g_d;
            s_q       <= s_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inx_q     <= inx_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign product_o   = product_q;
    assign nan_o       = nan_q;
    assign infinite_o  = inf_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign inexact_o   = inx_q;
endmodule
